// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One adder/subtractor is reused over 32 iterations, then a sign-fix cycle commits the result.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic             rd_hilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] raw_a;
    logic             sign_q;
    logic             sign_r;
    logic             is_div;
    logic             div_zero;

    logic             last_iter;
    logic             op_signed;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic             sub_ok;
    logic [WIDTH-1:0] sub_diff;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign last_iter = (count == CW'(WIDTH - 1));
    assign busy      = (state != IDLE);
    assign stall     = busy & (start | rd_hilo | wr_hi | wr_lo);

    // Operand magnitudes: signed ops take absolute values, unsigned ops pass through.
    assign op_signed = ~op[0];
    assign sa        = srcA[WIDTH-1] & op_signed;
    assign sb        = srcB[WIDTH-1] & op_signed;
    assign mag_a     = sa ? -srcA : srcA;
    assign mag_b     = sb ? -srcB : srcB;

    // Shift-add step: the multiplier sits in acc_lo and is consumed from bit 0.
    assign add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);

    // Restoring-division step: remainder fits in WIDTH bits whenever the trial succeeds.
    assign shifted  = {acc_hi, acc_lo[WIDTH-1]};
    assign sub_ok   = (shifted >= {1'b0, operand});
    assign sub_diff = shifted[WIDTH-1:0] - operand;

    assign product  = {acc_hi, acc_lo};
    assign prod_fix = sign_q ? -product : product;
    assign quot_fix = sign_q ? -acc_lo : acc_lo;
    assign rem_fix  = sign_r ? -acc_hi : acc_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = op[1] ? DIV : MUL;
            MUL:  if (last_iter) state_next = FIX;
            DIV:  if (last_iter) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and HI/LO; a start in IDLE takes priority over MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            operand  <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            raw_a    <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        operand  <= op[1] ? mag_b : mag_a;
                        acc_lo   <= op[1] ? mag_a : mag_b;
                        acc_hi   <= '0;
                        count    <= '0;
                        raw_a    <= srcA;
                        sign_q   <= sa ^ sb;
                        sign_r   <= sa;
                        is_div   <= op[1];
                        div_zero <= (srcB == '0);
                    end else begin
                        if (wr_hi) hi <= srcA;
                        if (wr_lo) lo <= srcA;
                    end
                end
                MUL: begin
                    {acc_hi, acc_lo} <= {add_sum, acc_lo[WIDTH-1:1]};
                    count            <= count + 1'b1;
                end
                DIV: begin
                    acc_hi <= sub_ok ? sub_diff : shifted[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], sub_ok};
                    count  <= count + 1'b1;
                end
                FIX: begin
                    if (is_div) begin
                        // Divide by zero reports all-ones quotient and the raw dividend.
                        if (div_zero) begin
                            lo <= '1;
                            hi <= raw_a;
                        end else begin
                            lo <= quot_fix;
                            hi <= rem_fix;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random bench for muldiv_unit: a scoreboard queue holds expected HI/LO
// computed from a behavioural multiply/divide model when each operation is issued.
module tb_muldiv_unit;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        wr_hi;
    logic        wr_lo;
    logic        rd_hilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cur_hi = 32'h0;
    logic [31:0] cur_lo = 32'h0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .srcA    (srcA),
        .srcB    (srcB),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .rd_hilo (rd_hilo),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input string tag);
        exp_t        e;
        logic [63:0] p;
        int          qa;
        int          qb;
        e.tag = tag;
        e.hi  = 32'h0;
        e.lo  = 32'h0;
        case (o)
            2'b00: begin
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p = {32'h0, a} * {32'h0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'h0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'h0;
                end else if (o == 2'b10) begin
                    qa = a;
                    qb = b;
                    e.lo = 32'(qa / qb);
                    e.hi = 32'(qa % qb);
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called on a falling edge; drives start for exactly one rising edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input string tag, input bit push);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        if (push) sb_q.push_back(model(o, a, b, tag));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n = 1;
        int busy_cycles = 0;
        while (done !== 1'b1 && n < 60) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            n++;
        end
        checkValue({tag, ":latency"}, 32'(n - 1), 32'd33);
        checkValue({tag, ":busy_cycles"}, 32'(busy_cycles), 32'd33);
        checkValue({tag, ":busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty observed=0 entries expected=1");
        end else begin
            e = sb_q.pop_front();
            checkValue({e.tag, ":hi"}, hi, e.hi);
            checkValue({e.tag, ":lo"}, lo, e.lo);
            cur_hi = e.hi;
            cur_lo = e.lo;
        end
    endtask

    task automatic runOp(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        applyStimulus(o, a, b, tag, 1'b1);
        waitDone(tag);
        checkOutput();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_seen;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        srcA    = 32'h0;
        srcB    = 32'h0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        rd_hilo = 1'b0;
        repeat (2) @(negedge clk);
        checkValue("reset:hi", hi, 32'h0);
        checkValue("reset:lo", lo, 32'h0);
        checkValue("reset:busy", 32'(busy), 32'd0);
        checkValue("reset:done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        @(negedge clk);
        checkValue("done_one_cycle", 32'(done), 32'd0);

        // Back-to-back: each start lands in the previous operation's done cycle.
        runOp(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
        runOp(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFB, "mult_neg5xneg5");
        runOp(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
        runOp(2'b11, 32'd7, 32'd2, "divu_7by2");
        runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_minint_by_neg1");
        runOp(2'b11, 32'd5, 32'd0, "divu_by_zero");
        runOp(2'b10, 32'hFFFF_FFFB, 32'd0, "div_neg5_by_zero");

        // Hazard run: rd_hilo held, a second start and an MTLO arrive mid-operation.
        rd_hilo = 1'b1;
        applyStimulus(2'b01, 32'h1234_5678, 32'd9, "hazard_multu", 1'b1);
        for (int n = 1; n <= 34; n++) begin
            if (n > 1) @(negedge clk);
            start = (n == 5);
            wr_lo = (n == 8);
            if (n == 5) begin
                op   = 2'b11;
                srcA = 32'd100;
                srcB = 32'd3;
            end
            if (n == 8) srcA = 32'hDEAD_BEEF;
            #1;
            checkValue($sformatf("hazard:stall_n%0d", n), 32'(stall), (n <= 33) ? 32'd1 : 32'd0);
            if (n == 20) begin
                checkValue("hazard:hi_stable", hi, cur_hi);
                checkValue("hazard:lo_stable", lo, cur_lo);
            end
        end
        checkValue("hazard:done", 32'(done), 32'd1);
        checkOutput();
        rd_hilo = 1'b0;
        @(negedge clk);
        checkValue("hazard:second_start_ignored", 32'(busy), 32'd0);

        wr_lo = 1'b1;
        srcA  = 32'h0000_1234;
        @(negedge clk);
        wr_lo = 1'b0;
        checkValue("mtlo:lo", lo, 32'h0000_1234);
        checkValue("mtlo:hi_kept", hi, cur_hi);

        wr_hi = 1'b1;
        wr_lo = 1'b1;
        srcA  = 32'h0000_CAFE;
        @(negedge clk);
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        checkValue("mthilo:hi", hi, 32'h0000_CAFE);
        checkValue("mthilo:lo", lo, 32'h0000_CAFE);

        wr_hi = 1'b1;
        applyStimulus(2'b01, 32'd6, 32'd7, "start_beats_mthi", 1'b1);
        wr_hi = 1'b0;
        waitDone("start_beats_mthi");
        checkOutput();

        // Reset in the middle of a MULTU discards it entirely.
        @(negedge clk);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h0001_2345, "aborted", 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkValue("midreset:busy", 32'(busy), 32'd0);
        checkValue("midreset:hi", hi, 32'h0);
        checkValue("midreset:lo", lo, 32'h0);
        cur_hi = 32'h0;
        cur_lo = 32'h0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        checkValue("midreset:no_done", 32'(done_seen), 32'd0);
        runOp(2'b01, 32'd6, 32'd7, "after_reset_6x7");

        for (int i = 0; i < 6; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            runOp(ro, ra, rb, $sformatf("random%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
